gpu_pixel_writeback: RTL and testbench

Pixel write-back stage directly downstream of the per-channel shading multiplier. It accepts one shaded 8-bit-per-channel RGB pixel per beat and applies the 4x4 ordered dither. It truncates to 5 bits per channel, optionally blends with the background VRAM pixel using one of the four semi-transparency equations, and applies mask-bit set/check rules. It emits a 16-bit VRAM word with a write-enable to the VRAM write queue through a 3-stage valid/ready pipeline at one pixel per clock.

---
 rtl/gpu_pixel_writeback_if.sv | 51 +++++
 rtl/gpu_pixel_writeback.sv | 165 ++++++++++++++++
 tb/tb_gpu_pixel_writeback.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pixel_writeback_if.sv
// ---------------------------------------------------------------------------
// gpu_pixel_writeback_if
// Bundles the pixel write-back stage's beat interface. The upstream half
// carries a shaded pixel together with its per-pixel control. The downstream
// half carries the finished VRAM word to the VRAM write queue.
//   master : the side that produces input beats and consumes output beats
//   slave  : the write-back stage itself
// Signals:
//   i_valid/o_ready            upstream handshake
//   i_r/i_g/i_b                8-bit shaded colour
//   i_x/i_y                    low screen-coordinate bits (dither index)
//   i_ditherEn                 apply ordered dither
//   i_blendEn/i_blendMode      semi-transparency enable and equation
//   i_srcMask                  texel STP bit
//   i_bg                       background VRAM pixel {mask,b5,g5,r5}
//   i_forceMask/i_checkMask    mask-bit set / check rules
//   o_valid/i_ready            downstream handshake
//   o_pixel/o_writeEn          VRAM word and commit flag
// ---------------------------------------------------------------------------
interface gpu_pixel_writeback_if;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_r;
  logic [7:0]  i_g;
  logic [7:0]  i_b;
  logic [1:0]  i_x;
  logic [1:0]  i_y;
  logic        i_ditherEn;
  logic        i_blendEn;
  logic [1:0]  i_blendMode;
  logic        i_srcMask;
  logic [15:0] i_bg;
  logic        i_forceMask;
  logic        i_checkMask;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_pixel;
  logic        o_writeEn;

  modport master (
    output i_valid, i_r, i_g, i_b, i_x, i_y, i_ditherEn, i_blendEn,
           i_blendMode, i_srcMask, i_bg, i_forceMask, i_checkMask, i_ready,
    input  o_ready, o_valid, o_pixel, o_writeEn
  );

  modport slave (
    input  i_valid, i_r, i_g, i_b, i_x, i_y, i_ditherEn, i_blendEn,
           i_blendMode, i_srcMask, i_bg, i_forceMask, i_checkMask, i_ready,
    output o_ready, o_valid, o_pixel, o_writeEn
  );
endinterface

// File: rtl/gpu_pixel_writeback.sv
// ---------------------------------------------------------------------------
// gpu_pixel_writeback
// Three-stage valid/ready pipeline that turns a shaded 8:8:8 pixel into a
// 16-bit VRAM word:
//   S1: 4x4 ordered dither, clamp to 0..255, truncate to 5 bits/channel
//   S2: optional semi-transparency blend against the background pixel
//   S3: output register holding {mask, b5, g5, r5} and the write enable
// Ports:
//   clk     rising-edge clock
//   i_nRst  asynchronous active-low reset
//   bus     gpu_pixel_writeback_if.slave (beat in, VRAM word out)
// ---------------------------------------------------------------------------
module gpu_pixel_writeback (
  input logic                  clk,
  input logic                  i_nRst,
  gpu_pixel_writeback_if.slave bus
);

  // Dither matrix lookup, indexed by the pixel's screen position.
  function automatic logic signed [3:0] dither_off(input logic [1:0] y,
                                                    input logic [1:0] x);
    logic signed [3:0] d;
    case ({y, x})
      4'h0: d = -4'sd4;  4'h1: d =  4'sd0;  4'h2: d = -4'sd3;  4'h3: d =  4'sd1;
      4'h4: d =  4'sd2;  4'h5: d = -4'sd2;  4'h6: d =  4'sd3;  4'h7: d = -4'sd1;
      4'h8: d = -4'sd3;  4'h9: d =  4'sd1;  4'hA: d = -4'sd4;  4'hB: d =  4'sd0;
      4'hC: d =  4'sd3;  4'hD: d = -4'sd1;  4'hE: d =  4'sd2;  default: d = -4'sd2;
    endcase
    return d;
  endfunction

  // ---------------- handshake ----------------
  logic r_s1_valid, r_s2_valid, r_s3_valid;
  logic w_s1_load, w_s2_load, w_s3_load;

  // A stage loads when it is empty or its occupant moves on this cycle, so
  // readiness ripples back from i_ready only; i_valid never feeds o_ready.
  assign w_s3_load = ~r_s3_valid | bus.i_ready;
  assign w_s2_load = ~r_s2_valid | w_s3_load;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign bus.o_ready = w_s1_load;

  // ---------------- S1: dither / truncate ----------------
  logic signed [3:0] w_d;
  logic [7:0]        w_c [3];
  logic [14:0]       w_f;

  assign w_d    = bus.i_ditherEn ? dither_off(bus.i_y, bus.i_x) : 4'sd0;
  assign w_c[0] = bus.i_r;
  assign w_c[1] = bus.i_g;
  assign w_c[2] = bus.i_b;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_s1
      logic signed [9:0] w_sum;
      assign w_sum = $signed({2'b00, w_c[gi]}) + $signed({{6{w_d[3]}}, w_d});
      // Negative underflows to 0; anything above 255 saturates to 31.
      assign w_f[5*gi +: 5] = w_sum[9] ? 5'd0 :
                              w_sum[8] ? 5'd31 : w_sum[7:3];
    end
  endgenerate

  logic [14:0] r_s1_f;
  logic        r_s1_blendEn;
  logic [1:0]  r_s1_mode;
  logic [14:0] r_s1_bg;
  logic        r_s1_mask;
  logic        r_s1_we;

  // ---------------- S2: blend ----------------
  logic [14:0] w_blend;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_s2
      logic [4:0]        w_bch;
      logic [4:0]        w_fch;
      logic [5:0]        w_add;
      logic [5:0]        w_add4;
      logic signed [5:0] w_sub;
      logic [4:0]        w_res;

      assign w_bch  = r_s1_bg[5*gi +: 5];
      assign w_fch  = r_s1_f[5*gi +: 5];
      assign w_add  = {1'b0, w_bch} + {1'b0, w_fch};
      assign w_add4 = {1'b0, w_bch} + {3'b000, w_fch[4:2]};
      assign w_sub  = $signed({1'b0, w_bch}) - $signed({1'b0, w_fch});

      always_comb begin
        w_res = w_fch;
        if (r_s1_blendEn) begin
          case (r_s1_mode)
            2'd0:    w_res = w_add[5:1];
            2'd1:    w_res = w_add[5] ? 5'd31 : w_add[4:0];
            2'd2:    w_res = w_sub[5] ? 5'd0 : w_sub[4:0];
            default: w_res = w_add4[5] ? 5'd31 : w_add4[4:0];
          endcase
        end
      end

      assign w_blend[5*gi +: 5] = w_res;
    end
  endgenerate

  logic [14:0] r_s2_rgb;
  logic        r_s2_mask;
  logic        r_s2_we;

  // ---------------- S3: output ----------------
  logic [15:0] r_s3_pixel;
  logic        r_s3_we;

  assign bus.o_valid   = r_s3_valid;
  assign bus.o_pixel   = r_s3_pixel;
  assign bus.o_writeEn = r_s3_we;

  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s3_valid   <= 1'b0;
      r_s1_f       <= '0;
      r_s1_blendEn <= 1'b0;
      r_s1_mode    <= '0;
      r_s1_bg      <= '0;
      r_s1_mask    <= 1'b0;
      r_s1_we      <= 1'b0;
      r_s2_rgb     <= '0;
      r_s2_mask    <= 1'b0;
      r_s2_we      <= 1'b0;
      r_s3_pixel   <= '0;
      r_s3_we      <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= bus.i_valid;
        if (bus.i_valid) begin
          r_s1_f       <= w_f;
          r_s1_blendEn <= bus.i_blendEn;
          r_s1_mode    <= bus.i_blendMode;
          r_s1_bg      <= bus.i_bg[14:0];
          // Mask decisions depend only on beat inputs, so resolve them here
          // and carry single bits instead of the whole background word.
          r_s1_mask    <= bus.i_srcMask | bus.i_forceMask;
          r_s1_we      <= ~(bus.i_checkMask & bus.i_bg[15]);
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_rgb  <= w_blend;
          r_s2_mask <= r_s1_mask;
          r_s2_we   <= r_s1_we;
        end
      end
      if (w_s3_load) begin
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_s3_pixel <= {r_s2_mask, r_s2_rgb};
          r_s3_we    <= r_s2_we;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writeback.sv
module tb_gpu_pixel_writeback;

  logic clk = 1'b0;
  logic i_nRst = 1'b0;
  always #5 clk = ~clk;

  gpu_pixel_writeback_if bus();

  gpu_pixel_writeback dut (
    .clk    (clk),
    .i_nRst (i_nRst),
    .bus    (bus)
  );

  typedef struct {
    int r, g, b, x, y, mode;
    bit den, ben, src, fm, cm;
    logic [15:0] bg;
  } beat_t;

  typedef struct {
    logic [15:0] pix;
    logic        we;
    int          cyc;
    bit          lat;
  } exp_t;

  int dtab [4][4] = '{'{-4, 0, -3, 1}, '{2, -2, 3, -1}, '{-3, 1, -4, 0}, '{3, -1, 2, -2}};

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nout = 0;
  bit          lat_chk = 1'b1;
  bit          dir_en = 1'b0;
  logic [16:0] dir_exp = '0;
  bit          rdy_mode = 1'b0;
  bit          rdy_force = 1'b1;
  bit          held = 1'b0;
  logic [15:0] held_pix = '0;
  logic        held_we = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: straight arithmetic from the dither/blend/mask rules.
  function automatic logic [16:0] model(input beat_t t);
    logic [15:0] p;
    int c, s, f, bb, res;
    p = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c = (ch == 0) ? t.r : (ch == 1) ? t.g : t.b;
      s = c + (t.den ? dtab[t.y][t.x] : 0);
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      f = s / 8;
      bb = int'(t.bg[5*ch +: 5]);
      if (!t.ben) res = f;
      else begin
        case (t.mode)
          0: res = (bb + f) / 2;
          1: res = (bb + f > 31) ? 31 : bb + f;
          2: res = (bb - f < 0) ? 0 : bb - f;
          default: res = (bb + f / 4 > 31) ? 31 : bb + f / 4;
        endcase
      end
      p[5*ch +: 5] = 5'(res);
    end
    p[15] = t.src | t.fm;
    return {~(t.cm & t.bg[15]), p};
  endfunction

  function automatic beat_t mk(input int r, g, b, x, y, input bit den, ben,
                               input int mode, input bit src,
                               input logic [15:0] bg, input bit fm, cm);
    beat_t t;
    t.r = r; t.g = g; t.b = b; t.x = x; t.y = y; t.den = den; t.ben = ben;
    t.mode = mode; t.src = src; t.bg = bg; t.fm = fm; t.cm = cm;
    return t;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), 16'($urandom),
              bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
  endfunction

  beat_t cur;

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input beat_t t, input bit use_exp, input logic [16:0] expv);
    int n;
    cur = t;
    dir_en = use_exp;
    dir_exp = expv;
    bus.i_r = 8'(t.r);  bus.i_g = 8'(t.g);  bus.i_b = 8'(t.b);
    bus.i_x = 2'(t.x);  bus.i_y = 2'(t.y);
    bus.i_ditherEn = t.den;  bus.i_blendEn = t.ben;
    bus.i_blendMode = 2'(t.mode);  bus.i_srcMask = t.src;
    bus.i_bg = t.bg;  bus.i_forceMask = t.fm;  bus.i_checkMask = t.cm;
    bus.i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<1000", n);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    dir_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  function automatic logic [16:0] pw(input bit we, m, input int b, g, r);
    return {we, m, 5'(b), 5'(g), 5'(r)};
  endfunction

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    bus.i_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  always @(posedge clk) begin
    cyc++;
    if (cyc > 95000) begin
      $display("FAIL watchdog actual=%0d required=<=95000 cycles", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // Scoreboard monitor: sampled on the falling edge, half a cycle away from
  // the DUT's active edge; transfers it sees happen on the next rising edge.
  always @(negedge clk) begin
    if (!i_nRst) begin
      held = 1'b0;
    end else begin
      chk("o_ready_rule", bus.o_ready, !(exp_q.size() == 3 && !bus.i_ready));
      if (held) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_pixel", bus.o_pixel, held_pix);
        chk("hold_we", bus.o_writeEn, held_we);
      end
      held = bus.o_valid && !bus.i_ready;
      held_pix = bus.o_pixel;
      held_we = bus.o_writeEn;
      if (bus.o_valid && bus.i_ready) begin
        nout++;
        $display("OUT %0d cyc=%0d pixel=%h we=%b", nout, cyc, bus.o_pixel, bus.o_writeEn);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", bus.o_pixel);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pixel", bus.o_pixel, e.pix);
          chk("writeEn", bus.o_writeEn, e.we);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_t e;
        logic [16:0] m;
        m = dir_en ? dir_exp : model(cur);
        e.pix = m[15:0];
        e.we = m[16];
        e.cyc = cyc;
        e.lat = lat_chk;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_r = '0; bus.i_g = '0; bus.i_b = '0; bus.i_x = '0; bus.i_y = '0;
    bus.i_ditherEn = 1'b0; bus.i_blendEn = 1'b0; bus.i_blendMode = '0;
    bus.i_srcMask = 1'b0; bus.i_bg = '0; bus.i_forceMask = 1'b0;
    bus.i_checkMask = 1'b0;
    bus.i_ready = 1'b1;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_ready", bus.o_ready, 1);
    chk("rst_o_pixel", bus.o_pixel, 0);
    chk("rst_o_writeEn", bus.o_writeEn, 0);
    i_nRst = 1'b1;

    // Directed corners, back to back, fixed expectations.
    lat_chk = 1'b1;
    send(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0, 0, 0), 1, pw(1, 0, 0, 0, 0));
    send(mk(255, 0, 0, 3, 1, 1, 0, 0, 0, 16'h0, 0, 0), 1, pw(1, 0, 0, 0, 31));
    send(mk(7, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0, 0, 0), 1, pw(1, 0, 0, 0, 0));
    send(mk(6, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0, 0, 0), 1, pw(1, 0, 0, 0, 1));
    send(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0), 1, pw(1, 0, 0, 0, 0));
    send(mk(160, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0010, 0, 0), 1, pw(1, 0, 0, 0, 18));
    send(mk(160, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0010, 0, 0), 1, pw(1, 0, 0, 0, 31));
    send(mk(160, 0, 0, 0, 0, 0, 1, 2, 0, 16'h0010, 0, 0), 1, pw(1, 0, 0, 0, 0));
    send(mk(160, 0, 0, 0, 0, 0, 1, 3, 0, 16'h0010, 0, 0), 1, pw(1, 0, 0, 0, 21));
    send(mk(160, 0, 0, 0, 0, 0, 0, 3, 0, 16'h0010, 0, 0), 1, pw(1, 0, 0, 0, 20));
    send(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h8000, 0, 1), 1, pw(0, 0, 0, 0, 0));
    send(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0), 1, pw(1, 1, 0, 0, 0));
    send(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h8000, 0, 0), 1, pw(1, 0, 0, 0, 0));

    // Streaming: 16 consecutive random beats at full rate.
    for (int i = 0; i < 16; i++) send(rnd_beat(), 0, '0);
    drain();

    // Backpressure: 6-cycle stall in the middle of a continuous stream.
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(rnd_beat(), 0, '0);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        rdy_force = 1'b0;
        repeat (6) @(posedge clk);
        rdy_force = 1'b1;
      end
    join
    drain();

    // Random soak with valid gaps and random downstream ready.
    rdy_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rnd_beat(), 0, '0);
    end
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk);
    drain();

    // Reset with three beats in flight.
    lat_chk = 1'b1;
    repeat (3) send(rnd_beat(), 0, '0);
    i_nRst = 1'b0;
    #1;
    chk("midrst_o_valid", bus.o_valid, 0);
    chk("midrst_o_pixel", bus.o_pixel, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    i_nRst = 1'b1;
    chk("postrst_o_ready", bus.o_ready, 1);
    chk("postrst_o_valid", bus.o_valid, 0);
    send(rnd_beat(), 0, '0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
